// File: rtl/sel_n_chan.sv
// N-channel min/max selector: runs a soc/eoc conversion on N producers, scans the
// captured samples one per cycle and hands the winner and its index to a dav_/rfd consumer.
module sel_n_chan #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic            clock,
  input  logic            reset_,
  input  logic [N*W-1:0]  x,
  input  logic [N-1:0]    eoc,
  output logic            soc,
  input  logic            mode,
  output logic [W-1:0]    out,
  output logic [IW-1:0]   idx,
  input  logic            rfd,
  output logic            dav_
);

  typedef enum logic [2:0] {START, WAIT, CMP, OUT, ACK} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state;
  logic [W-1:0]    smp [N];
  logic            mode_r;
  logic [W-1:0]    cand;
  logic [IW-1:0]   cidx;
  logic [IW-1:0]   cnt;

  logic            take;
  logic [W-1:0]    cand_nxt;
  logic [IW-1:0]   cidx_nxt;

  // Strict comparison so that on ties the earlier (lower-index) channel is kept.
  function automatic logic beats(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic want_max);
    return want_max ? (a > b) : (a < b);
  endfunction

  always_comb begin
    take     = beats(smp[cnt], cand, mode_r);
    cand_nxt = take ? smp[cnt] : cand;
    cidx_nxt = take ? cnt : cidx;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state  <= START;
      soc    <= 1'b0;
      dav_   <= 1'b1;
      out    <= '0;
      idx    <= '0;
      mode_r <= 1'b0;
      cand   <= '0;
      cidx   <= '0;
      cnt    <= '0;
      for (int k = 0; k < N; k++) smp[k] <= '0;
    end else begin
      case (state)
        // soc must have been seen high before the producers' eoc drop counts.
        START: begin
          if (soc && (eoc == '0)) begin
            soc   <= 1'b0;
            state <= WAIT;
          end else begin
            soc <= 1'b1;
          end
        end
        WAIT: begin
          if (eoc == '1) begin
            for (int k = 0; k < N; k++) smp[k] <= x[k*W +: W];
            mode_r <= mode;
            cnt    <= '0;
            state  <= CMP;
          end
        end
        // cnt==0 seeds the candidate; each later cycle folds in one channel.
        CMP: begin
          if (cnt == '0) begin
            cand <= smp[0];
            cidx <= '0;
            cnt  <= IW'(1);
          end else begin
            cand <= cand_nxt;
            cidx <= cidx_nxt;
            if (cnt == LAST) begin
              out   <= cand_nxt;
              idx   <= cidx_nxt;
              cnt   <= '0;
              state <= OUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // dav_ is low for at least one cycle even if rfd is already low on entry.
        OUT: begin
          if (!dav_ && !rfd) begin
            dav_  <= 1'b1;
            state <= ACK;
          end else begin
            dav_ <= 1'b0;
          end
        end
        ACK: begin
          if (rfd) begin
            soc   <= 1'b1;
            state <= START;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_n_chan.sv
// Bench for sel_n_chan (N=4, W=8): directed transactions, expected results queued at
// capture time and checked by a monitor whenever dav_ falls.
module tb_sel_n_chan;

  logic        clock;
  logic        reset_;
  logic [31:0] x;
  logic [3:0]  eoc;
  logic        soc;
  logic        mode;
  logic [7:0]  out;
  logic [1:0]  idx;
  logic        rfd;
  logic        dav_;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  e;
  logic        dav_q = 1'b1;

  sel_n_chan #(.N(4), .W(8), .IW(2)) dut (
    .clock (clock),
    .reset_(reset_),
    .x     (x),
    .eoc   (eoc),
    .soc   (soc),
    .mode  (mode),
    .out   (out),
    .idx   (idx),
    .rfd   (rfd),
    .dav_  (dav_)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: one result per falling edge of dav_.
  always @(negedge clock) begin
    if (reset_ && dav_q === 1'b1 && dav_ === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_out", out, e[7:0]);
        check("sb_idx", idx, e[9:8]);
      end
    end
    dav_q <= dav_;
  end

  // One full conversion + delivery. hold = cycles rfd stays 1 in OUT (0: rfd low early).
  task automatic run(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                     input logic [7:0] c3, input logic md, input logic [7:0] eo,
                     input logic [1:0] ei, input bit skew, input int hold, input bit abort);
    int c;
    c = 0;
    while (soc !== 1'b1 && c < 20) begin @(negedge clock); c++; end
    check("soc_ready", soc, 1);
    if (skew) begin
      for (int b = 0; b < 4; b++) begin
        eoc[b] = 1'b0;
        @(negedge clock);
        if (b < 3) check("soc_partial_eoc", soc, 1);
      end
    end else begin
      eoc = '0;
      @(negedge clock);
    end
    check("soc_drop", soc, 0);
    if (skew) begin
      x    = {4{8'hFF}};
      mode = md;
      for (int b = 0; b < 3; b++) begin
        eoc[b] = 1'b1;
        @(negedge clock);
      end
    end
    x    = {c3, c2, c1, c0};
    mode = md;
    eoc  = '1;
    if (!abort) exp_q.push_back({ei, eo});
    if (hold == 0) rfd = 1'b0;
    @(negedge clock);
    x    = '0;
    mode = ~md;
    if (abort) begin
      repeat (2) @(negedge clock);
      reset_ = 1'b0;
      #1;
      check("rst_soc", soc, 0);
      check("rst_dav", dav_, 1);
      check("rst_out", out, 0);
      check("rst_idx", idx, 0);
      @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      check("rst_soc_next", soc, 1);
      return;
    end
    c = 0;
    while (dav_ !== 1'b0 && c < 20) begin @(negedge clock); c++; end
    check("latency", c, 5);
    for (int i = 0; i < hold; i++) begin
      check("hold_dav", dav_, 0);
      check("hold_out", out, eo);
      check("hold_idx", idx, ei);
      @(negedge clock);
    end
    rfd = 1'b0;
    @(negedge clock);
    check("ack_dav", dav_, 1);
    check("ack_out_kept", out, eo);
    check("ack_idx_kept", idx, ei);
    rfd = 1'b1;
    @(negedge clock);
    check("restart_soc", soc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ = 1'b0;
    x      = '0;
    eoc    = '1;
    mode   = 1'b0;
    rfd    = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_soc", soc, 0);
    check("reset_dav", dav_, 1);
    check("reset_out", out, 0);
    check("reset_idx", idx, 0);
    reset_ = 1'b1;
    @(negedge clock);
    check("reset_soc_next", soc, 1);

    run(8'h40, 8'h12, 8'h90, 8'h33, 1'b0, 8'h12, 2'd1, 1'b0, 3,  1'b0);
    run(8'h40, 8'h12, 8'h90, 8'h33, 1'b1, 8'h90, 2'd2, 1'b0, 2,  1'b0);
    run(8'h07, 8'h05, 8'h05, 8'hFF, 1'b0, 8'h05, 2'd1, 1'b0, 1,  1'b0);
    run(8'h55, 8'h21, 8'hA0, 8'h60, 1'b1, 8'hA0, 2'd2, 1'b1, 10, 1'b0);
    run(8'h03, 8'h09, 8'h01, 8'h02, 1'b0, 8'h01, 2'd2, 1'b0, 0,  1'b0);
    run(8'hC0, 8'h10, 8'hC0, 8'hC0, 1'b1, 8'hC0, 2'd0, 1'b1, 1,  1'b0);
    run(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 8'h00, 2'd0, 1'b0, 1,  1'b1);
    run(8'hFE, 8'hFF, 8'h00, 8'h80, 1'b0, 8'h00, 2'd2, 1'b0, 2,  1'b0);

    repeat (2) @(negedge clock);
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
